// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way, 8-set branch target buffer.
package btb_pkg;

    localparam int INDEX_W    = 3;
    localparam int DEF_ADDR_W = 32;
    localparam int TAG_W      = DEF_ADDR_W - 5;

    function automatic int tag_width(input int addr_w);
        return addr_w - 5;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DEF_ADDR_W-1:0] target;
        logic [1:0]            ctr;
    } btb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2
    } btb_state_t;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: 8 entries, combinational IF read and EX lookup ports, single
// registered write port. Only the valid bits are reset.
module btb_way
    import btb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TW     = ADDR_W - 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TW-1:0]      rd_tag,
    output logic [ADDR_W-1:0]  rd_target,
    output logic [1:0]         rd_ctr,
    input  logic [INDEX_W-1:0] lk_index,
    output logic               lk_valid,
    output logic [TW-1:0]      lk_tag,
    output logic [ADDR_W-1:0]  lk_target,
    output logic [1:0]         lk_ctr,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TW-1:0]      wr_tag,
    input  logic [ADDR_W-1:0]  wr_target,
    input  logic [1:0]         wr_ctr
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [DEPTH-1:0]  valid;
    logic [TW-1:0]     tag_mem    [DEPTH];
    logic [ADDR_W-1:0] target_mem [DEPTH];
    logic [1:0]        ctr_mem    [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Payload needs no reset: it is never observed while valid is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]    <= wr_tag;
            target_mem[wr_index] <= wr_target;
            ctr_mem[wr_index]    <= wr_ctr;
        end
    end

    assign rd_valid  = valid[rd_index];
    assign rd_tag    = tag_mem[rd_index];
    assign rd_target = target_mem[rd_index];
    assign rd_ctr    = ctr_mem[rd_index];

    assign lk_valid  = valid[lk_index];
    assign lk_tag    = tag_mem[lk_index];
    assign lk_target = target_mem[lk_index];
    assign lk_ctr    = ctr_mem[lk_index];

endmodule

// File: rtl/btb_update_unit.sv
// BTB write side: accepts resolved branches, picks a way (hit, invalid, LRU
// victim) and updates it; also serves the combinational IF lookup port.
module btb_update_unit
    import btb_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_hit,
    output logic              rd_way,
    output logic [ADDR_W-1:0] rd_target,
    output logic              rd_pred_taken,
    output logic [2:0]        lru_index,
    input  logic              lru_bit,
    output logic              lru_touch,
    output logic              lru_way
);

    localparam int TW = ADDR_W - 5;

    btb_state_t state, state_nx;

    logic [ADDR_W-1:0] pc_q, target_q;
    logic              taken_q, way_q, hit_q;

    logic [INDEX_W-1:0] idx_q;
    logic [TW-1:0]      tag_q;
    assign idx_q = pc_q[4:2];
    assign tag_q = pc_q[ADDR_W-1:5];

    logic [1:0]                   rdv, lkv, rd_match, lk_match;
    logic [1:0][TW-1:0]           rdt, lkt;
    logic [1:0][ADDR_W-1:0]       rdtg, lktg;
    logic [1:0][1:0]              rdc, lkc;
    logic [1:0]                   wr_en;
    logic [ADDR_W-1:0]            wr_target;
    logic [1:0]                   wr_ctr;

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(.ADDR_W(ADDR_W), .TW(TW)) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .rd_index  (rd_pc[4:2]),
            .rd_valid  (rdv[w]),
            .rd_tag    (rdt[w]),
            .rd_target (rdtg[w]),
            .rd_ctr    (rdc[w]),
            .lk_index  (idx_q),
            .lk_valid  (lkv[w]),
            .lk_tag    (lkt[w]),
            .lk_target (lktg[w]),
            .lk_ctr    (lkc[w]),
            .wr_en     (wr_en[w]),
            .wr_index  (idx_q),
            .wr_tag    (tag_q),
            .wr_target (wr_target),
            .wr_ctr    (wr_ctr)
        );
        assign rd_match[w] = rdv[w] && (rdt[w] == rd_pc[ADDR_W-1:5]);
        assign lk_match[w] = lkv[w] && (lkt[w] == tag_q);
        assign wr_en[w]    = (state == WRITE) && (way_q == 1'(w));
    end

    // IF read port; way0 wins on a double match.
    assign rd_hit        = |rd_match;
    assign rd_way        = !rd_match[0] && rd_match[1];
    assign rd_target     = rd_match[0] ? rdtg[0] : (rd_match[1] ? rdtg[1] : '0);
    assign rd_pred_taken = rd_match[0] ? rdc[0][1] : (rd_match[1] ? rdc[1][1] : 1'b0);

    logic lk_hit, lk_way;
    always_comb begin
        lk_hit = |lk_match;
        if (lk_match[0])   lk_way = 1'b0;
        else if (lk_match[1]) lk_way = 1'b1;
        else if (!lkv[0])  lk_way = 1'b0;
        else if (!lkv[1])  lk_way = 1'b1;
        else               lk_way = ~lru_bit;
    end

    assign wr_target = (hit_q && !taken_q) ? lktg[way_q] : target_q;
    assign wr_ctr    = !hit_q  ? CTR_INIT :
                       taken_q ? ctr_inc(lkc[way_q]) : ctr_dec(lkc[way_q]);

    assign lru_index = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        upd_ready = 1'b0;
        lru_touch = 1'b0;
        lru_way   = 1'b0;
        unique case (state)
            IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) state_nx = LOOKUP;
            end
            LOOKUP: state_nx = (lk_hit || taken_q) ? WRITE : IDLE;
            WRITE: begin
                lru_touch = 1'b1;
                lru_way   = way_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
            way_q    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            if (state == IDLE && upd_valid) begin
                pc_q     <= upd_pc;
                target_q <= upd_target;
                taken_q  <= upd_taken;
            end
            if (state == LOOKUP) begin
                way_q <= lk_way;
                hit_q <= lk_hit;
            end
        end
    end

    // Word-offset bits and the low counter bit of the IF port carry no information here.
    logic unused_bits;
    assign unused_bits = ^{rd_pc[1:0], pc_q[1:0], rdc[0][0], rdc[1][0]};

endmodule

// File: tb/tb_btb_update_unit.sv
// Directed bench for btb_update_unit: expected LRU touches go into a queue that
// a negedge monitor drains; read-port results are compared to hand values.
module tb_btb_update_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] rd_pc = '0;
    logic        rd_hit, rd_way, rd_pred_taken;
    logic [31:0] rd_target;
    logic [2:0]  lru_index;
    logic        lru_bit = 1'b0;
    logic        lru_touch, lru_way;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    btb_update_unit #(.ADDR_W(32), .CTR_INIT(2'b10)) dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .rd_pc(rd_pc), .rd_hit(rd_hit), .rd_way(rd_way),
        .rd_target(rd_target), .rd_pred_taken(rd_pred_taken),
        .lru_index(lru_index), .lru_bit(lru_bit),
        .lru_touch(lru_touch), .lru_way(lru_way)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every lru_touch must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && lru_touch) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL lru_touch_unexpected: got idx=%0d way=%0d expected no touch",
                         lru_index, lru_way);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({lru_index, lru_way} !== e) begin
                    errors++;
                    $display("FAIL lru_touch: got idx=%0d way=%0d expected idx=%0d way=%0d",
                             lru_index, lru_way, e[3:1], e[0]);
                end
            end
        end
    end

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                             input logic lb, input bit wr, input logic wy, input int exp_low);
        int low;
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; lru_bit = lb;
        if (wr) exp_q.push_back({pc[4:2], wy});
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        low = 0;
        while (!upd_ready && low < 10) begin
            low++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 32'(low), 32'(exp_low));
    endtask

    task automatic check_rd(input string name, input logic [31:0] pc, input logic hit,
                            input logic way, input logic [31:0] tgt, input logic pt);
        rd_pc = pc;
        #1;
        chk({name, ".hit"}, 32'(rd_hit), 32'(hit));
        chk({name, ".way"}, 32'(rd_way), 32'(way));
        chk({name, ".target"}, rd_target, tgt);
        chk({name, ".pred"}, 32'(rd_pred_taken), 32'(pt));
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset.upd_ready", 32'(upd_ready), 32'd1);
        chk("reset.lru_touch", 32'(lru_touch), 32'd0);
        chk("reset.lru_index", 32'(lru_index), 32'd0);
        chk("reset.lru_way", 32'(lru_way), 32'd0);
        check_rd("reset_rd", 32'h100, 0, 0, 32'h0, 0);

        // allocation into empty set 0, then counter walk on hits
        do_update(32'h100, 32'h200, 1, 0, 1, 0, 2);
        check_rd("alloc", 32'h100, 1, 0, 32'h200, 1);
        do_update(32'h100, 32'h240, 1, 1, 1, 0, 2);       // ctr 3, target overwritten
        check_rd("hit_t1", 32'h100, 1, 0, 32'h240, 1);
        do_update(32'h100, 32'h200, 1, 1, 1, 0, 2);       // ctr 3 saturated
        check_rd("hit_t2", 32'h100, 1, 0, 32'h200, 1);
        do_update(32'h100, 32'h999, 0, 0, 1, 0, 2);       // ctr 2, target kept
        check_rd("hit_nt1", 32'h100, 1, 0, 32'h200, 1);
        do_update(32'h100, 32'h999, 0, 0, 1, 0, 2);       // ctr 1
        check_rd("hit_nt2", 32'h100, 1, 0, 32'h200, 0);
        do_update(32'h100, 32'h999, 0, 0, 1, 0, 2);       // ctr 0
        do_update(32'h100, 32'h999, 0, 0, 1, 0, 2);       // ctr 0 saturated
        do_update(32'h100, 32'h200, 1, 0, 1, 0, 2);       // ctr 1
        check_rd("hit_t_from0", 32'h100, 1, 0, 32'h200, 0);
        do_update(32'h100, 32'h200, 1, 0, 1, 0, 2);       // ctr 2
        check_rd("hit_t_to2", 32'h100, 1, 0, 32'h200, 1);

        // fill set 0 way1, then LRU replacement
        do_update(32'h1100, 32'h1200, 1, 0, 1, 1, 2);
        check_rd("fill_w1", 32'h1100, 1, 1, 32'h1200, 1);
        do_update(32'h2100, 32'h2200, 1, 0, 1, 1, 2);     // lru_bit=0 -> way1
        check_rd("repl_w1", 32'h2100, 1, 1, 32'h2200, 1);
        check_rd("repl_w1_gone", 32'h1100, 0, 0, 32'h0, 0);
        check_rd("repl_w1_keep", 32'h100, 1, 0, 32'h200, 1);
        do_update(32'h3100, 32'h3200, 1, 1, 1, 0, 2);     // lru_bit=1 -> way0
        check_rd("repl_w0", 32'h3100, 1, 0, 32'h3200, 1);
        check_rd("repl_w0_gone", 32'h100, 0, 0, 32'h0, 0);
        check_rd("repl_w0_keep", 32'h2100, 1, 1, 32'h2200, 1);

        // not-taken miss is dropped
        do_update(32'h300, 32'h400, 0, 0, 0, 0, 1);
        check_rd("nt_miss", 32'h300, 0, 0, 32'h0, 0);

        // other set
        do_update(32'h10C, 32'h5000, 1, 1, 1, 0, 2);
        check_rd("set3", 32'h10C, 1, 0, 32'h5000, 1);

        // reset during WRITE
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h44; upd_target = 32'h88; upd_taken = 1'b1;
        @(posedge clk);                 // accept
        @(negedge clk);
        upd_valid = 1'b0;
        @(posedge clk);                 // enter WRITE
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.upd_ready", 32'(upd_ready), 32'd1);
        chk("rst_mid.lru_touch", 32'(lru_touch), 32'd0);
        check_rd("rst_mid_44", 32'h44, 0, 0, 32'h0, 0);
        check_rd("rst_mid_3100", 32'h3100, 0, 0, 32'h0, 0);
        check_rd("rst_mid_10c", 32'h10C, 0, 0, 32'h0, 0);
        do_update(32'h44, 32'h88, 1, 1, 1, 0, 2);
        check_rd("post_rst", 32'h44, 1, 0, 32'h88, 1);

        @(negedge clk);
        chk("pending_touches", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
